// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/exception constants, next-PC select encoding, IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180;
    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_JUMP = 3'd1,
        NPC_BR   = 3'd2,
        NPC_EXC  = 3'd3,
        NPC_HOLD = 3'd4
    } npc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Redirect targets are word addresses; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, stall holds, otherwise captures the fetched word.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc4_i,
    output if_id_t          if_id_o
);

    if_id_t if_id_q, if_id_d;

    always_comb begin
        if_id_d = if_id_q;
        if (flush_i) begin
            if_id_d.inst  = NOP_WORD;
            if_id_d.valid = 1'b0;
        end else if (!stall_i) begin
            if_id_d.inst  = inst_i;
            if_id_d.pc4   = pc4_i;
            if_id_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q.inst  <= NOP_WORD;
            if_id_q.pc4   <= '0;
            if_id_q.valid <= 1'b0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, prioritised next-PC mux, IF/ID register and optional perf counters.
// Optional feature macro: FETCH_PERF_CNT_EN (stall/flush cycle counters).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = fetch_stage_pkg::EXC_VECTOR,
    parameter logic [31:0] NOP_INST   = fetch_stage_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                jump_en_i,
    input  logic [31:0]         jump_target_i,
    input  logic                br_taken_i,
    input  logic [31:0]         br_target_i,
    input  logic                exc_req_i,
    fetch_stage_if.master       imem,
    output logic [31:0]         pc_o,
    output logic [31:0]         if_id_inst_o,
    output logic [31:0]         if_id_pc4_o,
    output logic                if_id_valid_o,
    output logic [31:0]         perf_stall_cnt_o,
    output logic [31:0]         perf_flush_cnt_o
);
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    npc_sel_e        npc_sel;
    logic            flush;
    if_id_t          if_id;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign flush    = exc_req_i | br_taken_i | jump_en_i;

    // Older redirects win; any redirect overrides a stall.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (exc_req_i)       npc_sel = NPC_EXC;
        else if (br_taken_i) npc_sel = NPC_BR;
        else if (jump_en_i)  npc_sel = NPC_JUMP;
        else if (stall_i)    npc_sel = NPC_HOLD;
    end

    always_comb begin
        pc_d = pc_plus4;
        case (npc_sel)
            NPC_EXC:  pc_d = EXC_VECTOR;
            NPC_BR:   pc_d = align_word(br_target_i);
            NPC_JUMP: pc_d = align_word(jump_target_i);
            NPC_HOLD: pc_d = pc_q;
            default:  pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    if_id_reg #(.NOP_WORD(NOP_INST)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall_i),
        .flush_i (flush),
        .inst_i  (imem.imem_rdata),
        .pc4_i   (pc_plus4),
        .if_id_o (if_id)
    );

    assign imem.imem_addr = pc_q;
    assign pc_o           = pc_q;
    assign if_id_inst_o   = if_id.inst;
    assign if_id_pc4_o    = if_id.pc4;
    assign if_id_valid_o  = if_id.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (npc_sel == NPC_HOLD) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush)               flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'h0;
    assign perf_flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns 0x1000_0000 + word index.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, jump_en, br_taken, exc_req;
    logic [31:0] jump_target, br_target;
    logic [31:0] pc, inst, pc4, scnt, fcnt;
    logic        valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    always #5 clk = ~clk;

    fetch_stage_if imem_bus();

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign imem_bus.imem_rdata = word(imem_bus.imem_addr);

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall),
        .jump_en_i        (jump_en),
        .jump_target_i    (jump_target),
        .br_taken_i       (br_taken),
        .br_target_i      (br_target),
        .exc_req_i        (exc_req),
        .imem             (imem_bus),
        .pc_o             (pc),
        .if_id_inst_o     (inst),
        .if_id_pc4_o      (pc4),
        .if_id_valid_o    (valid),
        .perf_stall_cnt_o (scnt),
        .perf_flush_cnt_o (fcnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; jump_en = 0; br_taken = 0; exc_req = 0;
        jump_target = '0; br_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h0, NOP, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h inst=%h pc4=%h v=%b, expected pc=0 inst=0 pc4=0 v=0", pc, inst, pc4, valid);
        end
        n_checks++;
        if ({scnt, fcnt} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h expected 0/0", scnt, fcnt);
        end
        step();
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h4, word(32'h0), 32'h4, 1'b1}) begin
            n_fail++;
            $display("FAIL first_fetch: got pc=%h inst=%h pc4=%h v=%b, expected pc=4 inst=%h pc4=4 v=1", pc, inst, pc4, valid, word(32'h0));
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if ({pc, inst, pc4, valid} !== {32'(4*k), word(32'(4*k-4)), 32'(4*k), 1'b1}) begin
                n_fail++;
                $display("FAIL seq_%0d: got pc=%h inst=%h pc4=%h v=%b, expected pc=%h inst=%h", k, pc, inst, pc4, valid, 32'(4*k), word(32'(4*k-4)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) step();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({pc, inst, pc4, valid} !== {32'h10, word(32'h0C), 32'h10, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got pc=%h inst=%h pc4=%h v=%b, expected pc=10 inst=%h pc4=10 v=1", k, pc, inst, pc4, valid, word(32'h0C));
            end
        end
        stall = 0;
        step();
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h14, word(32'h10), 32'h14, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_resume: got pc=%h inst=%h pc4=%h v=%b, expected pc=14 inst=%h", pc, inst, pc4, valid, word(32'h10));
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({scnt, fcnt} !== {32'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL stall_counters: got %0d/%0d expected 3/0", scnt, fcnt);
        end
`endif
    endtask

    task automatic test_jump();
        do_reset();
        repeat (2) step();
        jump_en = 1; jump_target = 32'h40;
        step();
        n_checks++;
        if ({pc, inst, valid} !== {32'h40, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_bubble: got pc=%h inst=%h v=%b, expected pc=40 inst=0 v=0", pc, inst, valid);
        end
        clear_inputs();
        step();
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h44, word(32'h40), 32'h44, 1'b1}) begin
            n_fail++;
            $display("FAIL jump_target_fetch: got pc=%h inst=%h pc4=%h v=%b, expected pc=44 inst=%h pc4=44 v=1", pc, inst, pc4, valid, word(32'h40));
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        step();
        br_taken = 1; br_target = 32'h100;
        jump_en = 1; jump_target = 32'h40;
        stall = 1;
        step();
        n_checks++;
        if ({pc, inst, valid} !== {32'h100, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL br_over_jump_stall: got pc=%h inst=%h v=%b, expected pc=100 inst=0 v=0", pc, inst, valid);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({scnt, fcnt} !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL redirect_stall_counters: got %0d/%0d expected 0/1", scnt, fcnt);
        end
`endif
        clear_inputs();
        step();
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h104, word(32'h100), 32'h104, 1'b1}) begin
            n_fail++;
            $display("FAIL br_target_fetch: got pc=%h inst=%h pc4=%h v=%b, expected pc=104 inst=%h", pc, inst, pc4, valid, word(32'h100));
        end
    endtask

    task automatic test_exception_align();
        do_reset();
        step();
        exc_req = 1; br_taken = 1; br_target = 32'h100;
        step();
        n_checks++;
        if ({pc, inst, valid} !== {32'h8000_0180, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL exc_over_br: got pc=%h inst=%h v=%b, expected pc=80000180 inst=0 v=0", pc, inst, valid);
        end
        clear_inputs();
        step();
        n_checks++;
        if ({pc, inst, valid} !== {32'h8000_0184, word(32'h8000_0180), 1'b1}) begin
            n_fail++;
            $display("FAIL exc_vector_fetch: got pc=%h inst=%h v=%b, expected pc=80000184 inst=%h v=1", pc, inst, valid, word(32'h8000_0180));
        end
        br_taken = 1; br_target = 32'h107;
        step();
        n_checks++;
        if (pc !== 32'h104) begin
            n_fail++;
            $display("FAIL br_align: got pc=%h expected 104", pc);
        end
        clear_inputs();
        jump_en = 1; jump_target = 32'h203;
        step();
        n_checks++;
        if (pc !== 32'h200) begin
            n_fail++;
            $display("FAIL jump_align: got pc=%h expected 200", pc);
        end
        jump_target = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        step();
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h0, word(32'hFFFF_FFFC), 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h inst=%h pc4=%h v=%b, expected pc=0 inst=%h pc4=0 v=1", pc, inst, pc4, valid, word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        repeat (9) step();
        stall = 1;
        repeat (3) step();
        stall = 0;
        jump_en = 1; jump_target = 32'h20;
        step();
        jump_target = 32'h24;
        step();
        clear_inputs();
        n_checks++;
        if (pc !== 32'h24) begin
            n_fail++;
            $display("FAIL mid_run_setup: got pc=%h expected 24", pc);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({scnt, fcnt} !== {32'd3, 32'd2}) begin
            n_fail++;
            $display("FAIL counters_before_reset: got %0d/%0d expected 3/2", scnt, fcnt);
        end
`endif
        stall = 1; reset = 1;
        step();
        reset = 0; stall = 0;
        n_checks++;
        if ({pc, inst, pc4, valid} !== {32'h0, NOP, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_run_reset: got pc=%h inst=%h pc4=%h v=%b, expected pc=0 inst=0 pc4=0 v=0", pc, inst, pc4, valid);
        end
        n_checks++;
        if ({scnt, fcnt} !== 64'h0) begin
            n_fail++;
            $display("FAIL counters_after_reset: got %0d/%0d expected 0/0", scnt, fcnt);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch_priority();
        test_exception_align();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
